// File: rtl/calc_lr_pkg.sv
// Shared types and fixed-point helpers for the linear-rate calculator.
// Imported by the top and the sequential divider.
package calc_lr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    MUL,
    OUT
  } state_e;

  function automatic logic [127:0] one_fx(input int unsigned frac);
    return 128'(1) << frac;
  endfunction

  function automatic logic [127:0] sat_u(
    input logic [127:0] v,
    input int unsigned  w
  );
    logic [127:0] lim;
    lim = (128'(1) << w) - 128'(1);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/calc_lr_seq_div.sv
// Iterative restoring divider, one quotient bit per cycle, MSB first.
// done is high in the last busy cycle; quotient is valid after that edge.
module calc_lr_seq_div
  import calc_lr_pkg::*;
#(
  parameter int N = 32,
  parameter int D = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [D-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient
);

  localparam int CW = $clog2(N + 1);

  logic [N-1:0]  q_q, q_d;
  logic [D-1:0]  r_q, r_d;
  logic [D-1:0]  d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;

  logic [D:0] rs;
  logic [D:0] diff;
  logic       ge;

  always_comb begin
    rs    = {r_q, q_q[N-1]};
    diff  = rs - {1'b0, d_q};
    ge    = rs >= {1'b0, d_q};
    q_d   = q_q;
    r_d   = r_q;
    d_d   = d_q;
    cnt_d = cnt_q;
    busy_d = busy_q;
    if (start) begin
      q_d    = dividend;
      r_d    = '0;
      d_d    = divisor;
      cnt_d  = CW'(N);
      busy_d = 1'b1;
    end else if (busy_q) begin
      q_d   = {q_q[N-2:0], ge};
      r_d   = ge ? diff[D-1:0] : rs[D-1:0];
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q    <= '0;
      r_q    <= '0;
      d_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      r_q    <= r_d;
      d_q    <= d_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = busy_q && (cnt_q == CW'(1));
  assign quotient = q_q;

endmodule

// File: rtl/calc_linear_rate_mc.sv
// Per-task linear rate: (nnz/shape) * inv_avg_sparsity, fixed point,
// one request at a time through a handshaked divide/multiply pipeline.
module calc_linear_rate_mc
  import calc_lr_pkg::*;
#(
  parameter int SCORE_BITWIDTH = 32,
  parameter int DATA_WIDTH     = 16,
  parameter int FRAC_BITS      = 16,
  parameter int NUM_TASKS      = 4,
  localparam int TASK_W = (NUM_TASKS > 1) ? $clog2(NUM_TASKS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_vld,
  input  logic [TASK_W-1:0]         cfg_task,
  input  logic [SCORE_BITWIDTH-1:0] cfg_dat,
  input  logic                      in_vld,
  output logic                      in_rdy,
  input  logic [TASK_W-1:0]         in_task,
  input  logic [DATA_WIDTH-1:0]     in_nnz,
  input  logic [DATA_WIDTH-1:0]     in_shape,
  output logic                      out_vld,
  input  logic                      out_rdy,
  output logic [TASK_W-1:0]         out_task,
  output logic [SCORE_BITWIDTH-1:0] out_rate,
  output logic                      out_dbz
);

  localparam int SW = SCORE_BITWIDTH;
  localparam int QW = DATA_WIDTH + FRAC_BITS;
  localparam int PW = QW + SW;
  localparam logic [SW-1:0] ONE = SW'(one_fx(FRAC_BITS));

  state_e            state_q, state_d;
  logic [TASK_W-1:0] task_q, task_d;
  logic [SW-1:0]     inv_q, inv_d;
  logic              dbz_q, dbz_d;
  logic [SW-1:0]     rate_q, rate_d;
  logic [SW-1:0]     tbl_q [NUM_TASKS];
  logic [SW-1:0]     tbl_d [NUM_TASKS];

  logic          accept;
  logic [SW-1:0] inv_rd;
  logic          div_start, div_busy, div_done;
  logic [QW-1:0] div_quo;
  logic [QW-1:0] quo;
  logic [PW-1:0] prod;
  logic          quo_ovf;

  assign in_rdy = (state_q == IDLE) && reset;
  assign accept = in_vld && in_rdy;

  always_comb begin
    inv_rd = ONE;
    for (int i = 0; i < NUM_TASKS; i++) begin
      tbl_d[i] = tbl_q[i];
      if (in_task == TASK_W'(i)) inv_rd = tbl_q[i];
      if (cfg_vld && cfg_task == TASK_W'(i)) tbl_d[i] = cfg_dat;
    end
  end

  // Divide-by-zero skips the divider with an all-ones quotient.
  assign quo     = dbz_q ? '1 : div_quo;
  assign prod    = PW'(quo) * PW'(inv_q);
  assign quo_ovf = (PW'(quo) >> SW) != '0;

  always_comb begin
    state_d   = state_q;
    task_d    = task_q;
    inv_d     = inv_q;
    dbz_d     = dbz_q;
    rate_d    = rate_q;
    div_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          task_d    = in_task;
          inv_d     = inv_rd;
          dbz_d     = (in_shape == '0);
          div_start = (in_shape != '0);
          state_d   = (in_shape == '0) ? MUL : DIV;
        end
      end
      DIV: begin
        if (div_done || !div_busy) state_d = MUL;
      end
      MUL: begin
        rate_d  = quo_ovf ? '1 :
                  SW'(sat_u(128'(prod >> FRAC_BITS), SW));
        state_d = OUT;
      end
      OUT: begin
        if (out_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      task_q  <= '0;
      inv_q   <= '0;
      dbz_q   <= 1'b0;
      rate_q  <= '0;
      for (int i = 0; i < NUM_TASKS; i++) tbl_q[i] <= ONE;
    end else begin
      state_q <= state_d;
      task_q  <= task_d;
      inv_q   <= inv_d;
      dbz_q   <= dbz_d;
      rate_q  <= rate_d;
      for (int i = 0; i < NUM_TASKS; i++) tbl_q[i] <= tbl_d[i];
    end
  end

  calc_lr_seq_div #(
    .N(QW),
    .D(DATA_WIDTH)
  ) u_div (
    .clk     (clk),
    .reset   (reset),
    .start   (div_start),
    .dividend({in_nnz, {FRAC_BITS{1'b0}}}),
    .divisor (in_shape),
    .busy    (div_busy),
    .done    (div_done),
    .quotient(div_quo)
  );

  assign out_vld  = (state_q == OUT);
  assign out_task = task_q;
  assign out_rate = rate_q;
  assign out_dbz  = dbz_q;

endmodule
